// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and mapper pipeline latencies.
// Sprite/background mappers import this same package so their skew stays in lock-step.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Mapper pipeline: one cycle of ROM read, then one cycle of registered RGB.
  localparam int unsigned MAPPER_ROM_LAT = 1;
  localparam int unsigned MAPPER_OUT_LAT = 1;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a configurable idle value.
// DEPTH of zero degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with blank/sync outputs skewed to match the mapper pipeline.
// DrawX/DrawY and the strobes are undelayed; blank and hs/vs trail them by the mapper latencies.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned BLANK_LAT = MAPPER_ROM_LAT,
  parameter int unsigned SYNC_LAT  = MAPPER_ROM_LAT + MAPPER_OUT_LAT
) (
  input  logic   vga_clk,
  input  logic   reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   frame_start,
  output logic   vblank_start
);

  localparam coord_t HMax   = coord_t'(H_TOTAL - 1);
  localparam coord_t VMax   = coord_t'(V_TOTAL - 1);
  localparam coord_t HVis   = coord_t'(H_VISIBLE);
  localparam coord_t VVis   = coord_t'(V_VISIBLE);
  localparam coord_t HsBeg  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HsEnd  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VsBeg  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VsEnd  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t hc_q;
  coord_t vc_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (hc_q == HMax) begin
      hc_q <= '0;
      if (vc_q == VMax) begin
        vc_q <= '0;
      end else begin
        vc_q <= vc_q + coord_t'(1);
      end
    end else begin
      hc_q <= hc_q + coord_t'(1);
    end
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;

  logic vis;
  logic hs_n;
  logic vs_n;
  logic [1:0] sync_dly;

  // Reset gating keeps the zero-latency pass-through case idle while reset is held.
  always_comb begin
    vis  = (hc_q < HVis) && (vc_q < VVis) && !reset;
    hs_n = !((hc_q >= HsBeg) && (hc_q < HsEnd)) || reset;
    vs_n = !((vc_q >= VsBeg) && (vc_q < VsEnd)) || reset;
  end

  assign frame_start  = (hc_q == '0) && (vc_q == '0) && !reset;
  assign vblank_start = (hc_q == '0) && (vc_q == VVis) && !reset;

  vga_delay_line #(
    .WIDTH     (1),
    .DEPTH     (BLANK_LAT),
    .RESET_VAL (1'b0)
  ) u_blank_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (vis),
    .dout    (blank)
  );

  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_LAT),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     ({hs_n, vs_n}),
    .dout    (sync_dly)
  );

  assign hs = sync_dly[1];
  assign vs = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for the 640x480 raster generator: reset, line/frame timing, strobes, mid-frame reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic       vblank_start;

  int unsigned     tests = 0;
  int unsigned     fails = 0;
  longint unsigned cyc   = 0;
  longint unsigned f0_cyc = 0;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .hs           (hs),
    .vs           (vs),
    .frame_start  (frame_start),
    .vblank_start (vblank_start)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  // Advance at least one cycle until (x,y); an expired budget is a failure.
  task automatic run_until(input int x, input int y, input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < budget);
    if (!(DrawX == 10'(x) && DrawY == 10'(y))) begin
      tests++; fails++;
      $display("FAIL %s timeout: at (%0d,%0d) wanted (%0d,%0d)", name, DrawX, DrawY, x, y);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    tests++;
    if ({DrawX, DrawY} !== 20'd0) begin
      fails++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", DrawX, DrawY);
    end
    tests++;
    if ({blank, hs, vs, frame_start, vblank_start} !== 5'b01100) begin
      fails++;
      $display("FAIL reset_outs: got blank/hs/vs/fs/vb=%b expected 01100",
               {blank, hs, vs, frame_start, vblank_start});
    end
    reset = 1'b0;
    #1;
    f0_cyc = cyc;
    tests++;
    if ({DrawX, DrawY} !== 20'd0 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL release_c0: got (%0d,%0d) fs=%b expected (0,0) fs=1", DrawX, DrawY, frame_start);
    end
    tests++;
    if ({blank, hs, vs} !== 3'b011) begin
      fails++; $display("FAIL release_c0_outs: got blank/hs/vs=%b expected 011", {blank, hs, vs});
    end
    tick();
    tests++;
    if (DrawX !== 10'd1 || blank !== 1'b1 || frame_start !== 1'b0 || hs !== 1'b1) begin
      fails++;
      $display("FAIL release_c1: got x=%0d blank=%b fs=%b hs=%b expected x=1 blank=1 fs=0 hs=1",
               DrawX, blank, frame_start, hs);
    end
  endtask

  task automatic test_hline();
    int first = -1;
    int last  = -1;
    int low   = 0;
    int n     = 0;
    run_until(640, 0, 800, "h640");
    tests++;
    if (blank !== 1'b1) begin
      fails++; $display("FAIL blank_at_640: got %b expected 1", blank);
    end
    tick();
    tests++;
    if (DrawX !== 10'd641 || blank !== 1'b0) begin
      fails++; $display("FAIL blank_fall: got x=%0d blank=%b expected x=641 blank=0", DrawX, blank);
    end
    do begin
      tick();
      n++;
      if (hs === 1'b0) begin
        if (first < 0) first = int'(DrawX);
        last = int'(DrawX);
        low++;
      end
    end while (DrawX != 10'd0 && n < 800);
    tests++;
    if (first != 658 || last != 753 || low != 96) begin
      fails++;
      $display("FAIL hs_window: got first=%0d last=%0d len=%0d expected 658 753 96", first, last, low);
    end
    tests++;
    if (DrawX !== 10'd0 || DrawY !== 10'd1 || blank !== 1'b0) begin
      fails++;
      $display("FAIL line1_start: got (%0d,%0d) blank=%b expected (0,1) blank=0", DrawX, DrawY, blank);
    end
    tick();
    tests++;
    if (blank !== 1'b1) begin
      fails++; $display("FAIL blank_rise: got %b expected 1", blank);
    end
  endtask

  task automatic test_line_wrap();
    longint unsigned t_prev;
    run_until(799, 7, 8 * 800, "x799_y7");
    tick();
    tests++;
    if (DrawX !== 10'd0 || DrawY !== 10'd8) begin
      fails++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,8)", DrawX, DrawY);
    end
    t_prev = cyc;
    for (int k = 9; k <= 11; k++) begin
      run_until(0, k, 900, "line_start");
      tests++;
      if (cyc - t_prev != 800) begin
        fails++; $display("FAIL line_period_%0d: got %0d expected 800", k, cyc - t_prev);
      end
      t_prev = cyc;
    end
  endtask

  task automatic test_vertical();
    int blank_hi = 0;
    int vs_low   = 0;
    int vs_fx    = -1;
    int vs_fy    = -1;
    int vb_extra = 0;
    int px       = 0;
    int py       = 0;
    int n        = 0;
    run_until(0, 480, 480 * 800, "vblank");
    tests++;
    if (vblank_start !== 1'b1 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL vblank_strobe: got vb=%b fs=%b expected vb=1 fs=0", vblank_start, frame_start);
    end
    do begin
      px = int'(DrawX);
      py = int'(DrawY);
      tick();
      n++;
      if (blank === 1'b1) blank_hi++;
      if (vblank_start === 1'b1) vb_extra++;
      if (vs === 1'b0) begin
        if (vs_fx < 0) begin
          vs_fx = int'(DrawX);
          vs_fy = int'(DrawY);
        end
        vs_low++;
      end
    end while (!(DrawX == 10'd0 && DrawY == 10'd0) && n < 45 * 800 + 5);
    tests++;
    if (blank_hi != 0) begin
      fails++; $display("FAIL vblank_blank: got %0d visible cycles expected 0", blank_hi);
    end
    tests++;
    if (vs_low != 1600 || vs_fx != 2 || vs_fy != 490) begin
      fails++;
      $display("FAIL vs_window: got len=%0d start=(%0d,%0d) expected len=1600 start=(2,490)",
               vs_low, vs_fx, vs_fy);
    end
    tests++;
    if (vb_extra != 0) begin
      fails++; $display("FAIL vblank_once: got %0d extra pulses expected 0", vb_extra);
    end
    tests++;
    if (px != 799 || py != 524 || DrawX !== 10'd0 || DrawY !== 10'd0 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) fs=%b expected (799,524)->(0,0) fs=1",
               px, py, DrawX, DrawY, frame_start);
    end
    tests++;
    if (cyc - f0_cyc != 420000) begin
      fails++; $display("FAIL frame_period_0: got %0d expected 420000", cyc - f0_cyc);
    end
  endtask

  task automatic test_frame_period();
    longint unsigned t1 = cyc;
    int vb = 0;
    int n  = 0;
    do begin
      tick();
      n++;
      if (vblank_start === 1'b1) vb++;
    end while (frame_start !== 1'b1 && n < 420005);
    tests++;
    if (cyc - t1 != 420000 || DrawX !== 10'd0 || DrawY !== 10'd0) begin
      fails++;
      $display("FAIL frame_period_1: got %0d at (%0d,%0d) expected 420000 at (0,0)",
               cyc - t1, DrawX, DrawY);
    end
    tests++;
    if (vb != 1) begin
      fails++; $display("FAIL vblank_per_frame: got %0d expected 1", vb);
    end
  endtask

  task automatic test_mid_frame_reset();
    run_until(300, 200, 201 * 800, "x300_y200");
    tests++;
    if (blank !== 1'b1) begin
      fails++; $display("FAIL mid_pre_blank: got %b expected 1", blank);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || {blank, hs, vs} !== 3'b011) begin
      fails++;
      $display("FAIL mid_reset_edge: got (%0d,%0d) blank/hs/vs=%b expected (0,0) 011",
               DrawX, DrawY, {blank, hs, vs});
    end
    tick();
    tick();
    tests++;
    if ({blank, hs, vs, frame_start, vblank_start} !== 5'b01100 || DrawX !== 10'd0) begin
      fails++;
      $display("FAIL mid_reset_hold: got x=%0d blank/hs/vs/fs/vb=%b expected x=0 01100",
               DrawX, {blank, hs, vs, frame_start, vblank_start});
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({DrawX, DrawY} !== 20'd0 || frame_start !== 1'b1 || {blank, hs, vs} !== 3'b011) begin
      fails++;
      $display("FAIL mid_release_c0: got (%0d,%0d) fs=%b blank/hs/vs=%b expected (0,0) fs=1 011",
               DrawX, DrawY, frame_start, {blank, hs, vs});
    end
    tick();
    tests++;
    if (DrawX !== 10'd1 || blank !== 1'b1 || frame_start !== 1'b0 || {hs, vs} !== 2'b11) begin
      fails++;
      $display("FAIL mid_release_c1: got x=%0d blank=%b fs=%b hs/vs=%b expected x=1 1 0 11",
               DrawX, blank, frame_start, {hs, vs});
    end
    tick();
    tests++;
    if ({blank, hs, vs} !== 3'b111) begin
      fails++; $display("FAIL mid_release_c2: got blank/hs/vs=%b expected 111", {blank, hs, vs});
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_line_wrap();
    test_vertical();
    test_frame_period();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz raster that every sprite/background mapper consumes.
- Drives the DrawX/DrawY pixel coordinates and the active-high display-enable `blank` into the mappers.
- Drives hs/vs to the VGA connector and frame/vblank strobes to game logic.
- Output timing is skewed to match the mapper pipeline: ROM read (1 cycle), then registered RGB (1 cycle).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- BLANK_LAT, 1, cycles `blank` lags DrawX/DrawY (ROM read latency)
- SYNC_LAT, 2, cycles hs/vs lag DrawX/DrawY (ROM + RGB output register)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- DrawX  out  10  current column counter hc, 0..H_TOTAL-1
- DrawY  out  10  current line counter vc, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel; delayed BLANK_LAT cycles
- hs  out  1  hsync, active-low; delayed SYNC_LAT cycles
- vs  out  1  vsync, active-low; delayed SYNC_LAT cycles
- frame_start  out  1  one-cycle pulse, aligned with DrawX/DrawY
- vblank_start  out  1  one-cycle pulse, aligned with DrawX/DrawY

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- hc counter: increments every vga_clk. At H_TOTAL-1 it wraps to 0 and vc increments.
- vc counter: wraps to 0 at V_TOTAL-1, only coincident with the hc wrap.
- Full-frame wrap: (799,524) -> (0,0) in a single cycle.
- DrawX = hc and DrawY = vc, both registered with zero additional latency. Widths are exactly 10 bits; no saturation is needed.
- Undelayed internal terms:
  - vis = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - hs_n = !(hc >= H_VISIBLE+H_FRONT && hc < H_VISIBLE+H_FRONT+H_SYNC), low for hc 656..751
  - vs_n = !(vc >= V_VISIBLE+V_FRONT && vc < V_VISIBLE+V_FRONT+V_SYNC), low for vc 490..491
- Delayed outputs:
  - blank = vis delayed BLANK_LAT registers.
  - hs/vs = hs_n/vs_n delayed SYNC_LAT registers.
  - Delay registers shift every cycle; there is no enable.
- Strobes:
  - frame_start = (hc==0 && vc==0) && !reset.
  - vblank_start = (hc==0 && vc==V_VISIBLE) && !reset.
  - Each is high exactly one cycle per frame.
- Reset, asserted in any cycle including mid-frame:
  - Next edge: hc = vc = 0, and every delay stage is loaded with its inactive value (blank 0, hs 1, vs 1).
  - Held for as long as reset is high.
  - While reset is high: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, vblank_start=0.
- First cycle after reset release:
  - DrawX/DrawY = (0,0) and frame_start = 1.
  - blank goes to 1 BLANK_LAT cycles later.
  - hs/vs remain 1 (inactive region).
- BLANK_LAT=0 or SYNC_LAT=0 means combinational pass-through of the undelayed term.
- No other modes exist. Timing parameters are elaboration-time only.

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants and derived H_TOTAL/V_TOTAL
  - the coordinate typedef coord_t (logic [9:0])
  - MAPPER_ROM_LAT=1 and MAPPER_OUT_LAT=1
- BLANK_LAT and SYNC_LAT defaults are derived from MAPPER_ROM_LAT and MAPPER_OUT_LAT; sprite mappers import the same package.
- One sub-module: vga_delay_line.
  - Parameters: WIDTH, DEPTH, RESET_VAL.
  - Synchronous-reset shift register.
  - Instantiated once for blank and once for {hs,vs}.

Test Plan:
- Reset release:
  - Hold reset 5 cycles, then release.
  - Cycle 0 after release: DrawX=0, DrawY=0, frame_start=1, blank=0, hs=vs=1.
  - Cycle 1: blank=1, frame_start=0.
- Horizontal timing, line 0:
  - blank falls 1 cycle after DrawX=640 and rises 1 cycle after DrawX wraps to 0.
  - hs low from 2 cycles after DrawX=656 through 2 cycles after DrawX=751, i.e. exactly 96 cycles.
- Line wrap:
  - At DrawX=799, DrawY=7, the next cycle gives DrawX=0, DrawY=8.
  - 800 cycles per line across 3 consecutive lines.
- Vertical timing and strobes:
  - vblank_start high exactly at (0,480).
  - vs low for exactly 2*800=1600 cycles, starting 2 cycles after (0,490).
  - blank stays 0 for all of lines 480..524.
- Frame wrap:
  - At (799,524) the next cycle is (0,0) with frame_start=1.
  - Successive frame_start pulses are exactly 420000 cycles apart, checked over 2 frames.
- Mid-frame reset:
  - Assert reset for 3 cycles at (300,200) while blank=1.
  - On the following edge: DrawX=0, blank=0, hs=vs=1.
  - After release, sequence identical to the reset-release scenario, with no stale blank=1 or hs=0 leaking from the delay line.
